// File: rtl/integ_seq_gen_pkg.sv
// integ_seq_pkg: shared types for the integrator switch/charge-pump sequencer.
//   mode_e  : o_cp mode encoding (normal, inverted, off, hold)
//   state_e : sequencer FSM states
//   cp_calc : o_cp value from mode, state and "inside the cp-off guard" flag
package integ_seq_pkg;

   typedef enum logic [1:0] {
      MODE_NORM = 2'd0,
      MODE_INV  = 2'd1,
      MODE_OFF  = 2'd2,
      MODE_HOLD = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIGH,
      ST_GAP,
      ST_LOW,
      ST_DONE,
      ST_ERR
   } state_e;

   // Outside the three running phases o_cp is always low, whatever the mode.
   function automatic logic cp_calc(mode_e m, state_e s, logic guard);
      logic norm;
      logic res;
      norm = 1'b0;
      res  = 1'b0;
      case (s)
         ST_HIGH: norm = ~guard;
         ST_GAP:  norm = 1'b0;
         ST_LOW:  norm = 1'b1;
         default: norm = 1'b0;
      endcase
      if (s == ST_HIGH || s == ST_GAP || s == ST_LOW) begin
         case (m)
            MODE_NORM: res = norm;
            MODE_INV:  res = ~norm;
            MODE_OFF:  res = 1'b0;
            default:   res = 1'b1;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/integ_seq_gen_if.sv
// integ_seq_gen_if: configuration inputs and control outputs of the sequencer.
//   master : register-file / front-end side (drives config, reads outputs)
//   slave  : sequencer side
interface integ_seq_gen_if #(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 16
) ();
   logic               i_en;
   logic [1:0]         i_mode;
   logic [CNT_W-1:0]   i_T1;
   logic [CNT_W-1:0]   i_T2;
   logic [CNT_W-1:0]   i_T3;
   logic [CNT_W-1:0]   i_T4;
   logic [BURST_W-1:0] i_burst;
   logic               o_sw;
   logic               o_cp;
   logic               o_sync;
   logic [BURST_W-1:0] o_per_cnt;
   logic               o_done;
   logic               o_err;

   modport master (
      output i_en, i_mode, i_T1, i_T2, i_T3, i_T4, i_burst,
      input  o_sw, o_cp, o_sync, o_per_cnt, o_done, o_err
   );

   modport slave (
      input  i_en, i_mode, i_T1, i_T2, i_T3, i_T4, i_burst,
      output o_sw, o_cp, o_sync, o_per_cnt, o_done, o_err
   );
endinterface

// File: rtl/integ_seq_gen_shadow.sv
// integ_seq_shadow: period-boundary shadow of the sequencer configuration.
//   i_load      : capture strobe (period start)
//   i_mode..    : live configuration inputs
//   o_mode..    : shadowed fields used during the running period
//   o_in_valid  : validity of the live inputs, judged on the load edge
// T1 is only ever needed on the load edge itself (it sizes the first phase),
// so it is validated but not held.
module integ_seq_shadow
   import integ_seq_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic [1:0]         i_mode,
   input  logic [CNT_W-1:0]   i_T1,
   input  logic [CNT_W-1:0]   i_T2,
   input  logic [CNT_W-1:0]   i_T3,
   input  logic [CNT_W-1:0]   i_T4,
   input  logic [BURST_W-1:0] i_burst,
   output mode_e              o_mode,
   output logic [CNT_W-1:0]   o_T2,
   output logic [CNT_W-1:0]   o_T3,
   output logic [CNT_W-1:0]   o_T4,
   output logic [BURST_W-1:0] o_burst,
   output logic               o_in_valid
);

   logic [CNT_W:0] per_len;

   // Widened by one bit so T1+T2 can never wrap back to zero.
   assign per_len    = {1'b0, i_T1} + {1'b0, i_T2};
   assign o_in_valid = (i_T4 <= i_T1) && (i_T3 <= i_T2) && (per_len != '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_mode  <= MODE_NORM;
         o_T2    <= '0;
         o_T3    <= '0;
         o_T4    <= '0;
         o_burst <= '0;
      end else if (i_load) begin
         o_mode  <= mode_e'(i_mode);
         o_T2    <= i_T2;
         o_T3    <= i_T3;
         o_T4    <= i_T4;
         o_burst <= i_burst;
      end
   end

endmodule

// File: rtl/integ_seq_gen.sv
// integ_seq_gen: integrator switch / charge-pump sequencer.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : i_en, i_mode, i_T1..i_T4, i_burst in;
//                    o_sw, o_cp, o_sync, o_per_cnt, o_done, o_err out
// A period is HIGH (T1) -> GAP (T3) -> LOW (T2-T3); zero-length phases are
// skipped. One down-counter holds the cycles left in the current phase,
// including the current one, so a phase ends when it reads 1.
module integ_seq_gen
   import integ_seq_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   integ_seq_gen_if.slave   bus
);

   state_e             state, nstate;
   logic [CNT_W-1:0]   cnt, ncnt;
   logic [BURST_W-1:0] nper;
   logic               fin, pend, start;

   mode_e              sh_mode, cur_mode;
   logic [CNT_W-1:0]   sh_t2, sh_t3, sh_t4, cur_t4;
   logic [BURST_W-1:0] sh_burst;
   logic               in_valid;

   integ_seq_shadow #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_shadow (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (start),
      .i_mode     (bus.i_mode),
      .i_T1       (bus.i_T1),
      .i_T2       (bus.i_T2),
      .i_T3       (bus.i_T3),
      .i_T4       (bus.i_T4),
      .i_burst    (bus.i_burst),
      .o_mode     (sh_mode),
      .o_T2       (sh_t2),
      .o_T3       (sh_t3),
      .o_T4       (sh_t4),
      .o_burst    (sh_burst),
      .o_in_valid (in_valid)
   );

   // On a load edge the outputs for the new period already follow the
   // incoming configuration, not the old shadow.
   assign cur_mode = start ? mode_e'(bus.i_mode) : sh_mode;
   assign cur_t4   = start ? bus.i_T4 : sh_t4;
   assign fin      = (cnt == CNT_W'(1));

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      nper   = bus.o_per_cnt;
      pend   = 1'b0;
      start  = 1'b0;

      case (state)
         ST_IDLE: start = 1'b1;
         ST_HIGH: begin
            if (!fin)               ncnt = cnt - CNT_W'(1);
            else if (sh_t3 != '0)   begin nstate = ST_GAP; ncnt = sh_t3; end
            else if (sh_t2 != sh_t3) begin nstate = ST_LOW; ncnt = sh_t2 - sh_t3; end
            else                    pend = 1'b1;
         end
         ST_GAP: begin
            if (!fin)               ncnt = cnt - CNT_W'(1);
            else if (sh_t2 != sh_t3) begin nstate = ST_LOW; ncnt = sh_t2 - sh_t3; end
            else                    pend = 1'b1;
         end
         ST_LOW: begin
            if (!fin) ncnt = cnt - CNT_W'(1);
            else      pend = 1'b1;
         end
         default: ;  // DONE / ERR hold until i_en drops
      endcase

      if (pend) begin
         nper = (&bus.o_per_cnt) ? bus.o_per_cnt : bus.o_per_cnt + BURST_W'(1);
         if (sh_burst != '0 && nper == sh_burst) nstate = ST_DONE;
         else                                    start  = 1'b1;
      end

      // First phase of the new period comes straight from the live inputs.
      // A valid config has T1+T2 != 0, so with T1=T3=0 the LOW phase is non-empty.
      if (start) begin
         if (!in_valid)            begin nstate = ST_ERR;  ncnt = '0; end
         else if (bus.i_T1 != '0)  begin nstate = ST_HIGH; ncnt = bus.i_T1; end
         else if (bus.i_T3 != '0)  begin nstate = ST_GAP;  ncnt = bus.i_T3; end
         else                      begin nstate = ST_LOW;  ncnt = bus.i_T2; end
      end

      // Abort wins over everything, including a coinciding period end.
      if (!bus.i_en) begin
         nstate = ST_IDLE;
         ncnt   = '0;
         nper   = '0;
         start  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         bus.o_sw      <= 1'b0;
         bus.o_cp      <= 1'b0;
         bus.o_sync    <= 1'b0;
         bus.o_per_cnt <= '0;
         bus.o_done    <= 1'b0;
         bus.o_err     <= 1'b0;
      end else begin
         state         <= nstate;
         cnt           <= ncnt;
         bus.o_sw      <= (nstate == ST_HIGH);
         bus.o_cp      <= cp_calc(cur_mode, nstate, ncnt <= cur_t4);
         bus.o_sync    <= start && in_valid;
         bus.o_per_cnt <= nper;
         bus.o_done    <= (nstate == ST_DONE);
         bus.o_err     <= (nstate == ST_ERR);
      end
   end

endmodule
